// File: rtl/cmp_result_tally_pkg.sv
// Shared definitions for the comparator result tally block: FSM state
// encoding and the default counter width.
package cmp_result_tally_pkg;

  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_REPORT  = 2'd2
  } tally_state_e;

  // One-bit flag widened to a counter increment of the given width.
  function automatic logic [31:0] bit_to_inc(input logic b);
    return {31'd0, b};
  endfunction

endpackage : cmp_result_tally_pkg

// File: rtl/cmp_result_tally.sv
// Comparator result tally: collects a window of valid ans1/ans2 samples,
// counts highs and disagreements, remembers the first disagreeing sample
// index and presents one summary record over a valid/ready handshake.
module cmp_result_tally
  import cmp_result_tally_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] win_len,
  input  logic             in_valid,
  input  logic             ans1,
  input  logic             ans2,
  input  logic             out_ready,
  output logic             busy,
  output logic             out_valid,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt_diff,
  output logic             diff_seen,
  output logic [CNT_W-1:0] first_diff_idx
);

  tally_state_e     state_r;
  logic [CNT_W-1:0] len_r;
  logic [CNT_W-1:0] idx_r;

  logic             diff_s;
  logic             last_s;
  logic [CNT_W-1:0] inc1_s;
  logic [CNT_W-1:0] inc2_s;
  logic [CNT_W-1:0] incd_s;
  logic [31:0]      inc1_w_s;
  logic [31:0]      inc2_w_s;
  logic [31:0]      incd_w_s;

  // Per-sample increments and detection of the window's final sample.
  always_comb begin
    diff_s   = ans1 ^ ans2;
    inc1_w_s = bit_to_inc(ans1);
    inc2_w_s = bit_to_inc(ans2);
    incd_w_s = bit_to_inc(diff_s);
    inc1_s   = inc1_w_s[CNT_W-1:0];
    inc2_s   = inc2_w_s[CNT_W-1:0];
    incd_s   = incd_w_s[CNT_W-1:0];
    // len_r is at least 1 whenever COLLECT is active, so this never underflows there.
    if (idx_r == (len_r - {{(CNT_W-1){1'b0}}, 1'b1})) begin
      last_s = 1'b1;
    end else begin
      last_s = 1'b0;
    end
  end

  // Window FSM with the counter datapath and registered record outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      len_r          <= {CNT_W{1'b0}};
      idx_r          <= {CNT_W{1'b0}};
      busy           <= 1'b0;
      out_valid      <= 1'b0;
      cnt1           <= {CNT_W{1'b0}};
      cnt2           <= {CNT_W{1'b0}};
      cnt_diff       <= {CNT_W{1'b0}};
      diff_seen      <= 1'b0;
      first_diff_idx <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            len_r          <= win_len;
            idx_r          <= {CNT_W{1'b0}};
            cnt1           <= {CNT_W{1'b0}};
            cnt2           <= {CNT_W{1'b0}};
            cnt_diff       <= {CNT_W{1'b0}};
            diff_seen      <= 1'b0;
            first_diff_idx <= {CNT_W{1'b0}};
            busy           <= 1'b1;
            if (win_len != {CNT_W{1'b0}}) begin
              state_r   <= ST_COLLECT;
              out_valid <= 1'b0;
            end else begin
              // Empty window: report the all-zero record straight away.
              state_r   <= ST_REPORT;
              out_valid <= 1'b1;
            end
          end
        end
        ST_COLLECT: begin
          if (in_valid) begin
            cnt1     <= cnt1 + inc1_s;
            cnt2     <= cnt2 + inc2_s;
            cnt_diff <= cnt_diff + incd_s;
            if (diff_s && !diff_seen) begin
              first_diff_idx <= idx_r;
              diff_seen      <= 1'b1;
            end
            idx_r <= idx_r + {{(CNT_W-1){1'b0}}, 1'b1};
            if (last_s) begin
              state_r   <= ST_REPORT;
              out_valid <= 1'b1;
            end
          end
        end
        ST_REPORT: begin
          if (out_ready) begin
            state_r   <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule : cmp_result_tally

// File: tb/tb_cmp_result_tally.sv
// Self-checking bench for cmp_result_tally: directed vector table,
// hand-written corner sequences and randomized windows checked against
// a counting model of the window rules.
module tb_cmp_result_tally;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] win_len;
  logic       in_valid;
  logic       ans1;
  logic       ans2;
  logic       out_ready;
  logic       busy;
  logic       out_valid;
  logic [7:0] cnt1;
  logic [7:0] cnt2;
  logic [7:0] cnt_diff;
  logic       diff_seen;
  logic [7:0] first_diff_idx;

  int n_checks = 0;
  int n_errors = 0;

  // sample store for the current window
  bit s_a1  [0:299];
  bit s_a2  [0:299];
  int s_gap [0:299];

  typedef struct {
    int         len;
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] gap;
    int         e1;
    int         e2;
    int         ed;
    int         es;
    int         ef;
  } vec_t;

  vec_t vt [6];

  cmp_result_tally #(.CNT_W(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .win_len        (win_len),
    .in_valid       (in_valid),
    .ans1           (ans1),
    .ans2           (ans2),
    .out_ready      (out_ready),
    .busy           (busy),
    .out_valid      (out_valid),
    .cnt1           (cnt1),
    .cnt2           (cnt2),
    .cnt_diff       (cnt_diff),
    .diff_seen      (diff_seen),
    .first_diff_idx (first_diff_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_record(input string tag, input int e1, input int e2,
                              input int ed, input int es, input int ef);
    check({tag, " cnt1"}, int'(cnt1), e1);
    check({tag, " cnt2"}, int'(cnt2), e2);
    check({tag, " cnt_diff"}, int'(cnt_diff), ed);
    check({tag, " diff_seen"}, int'(diff_seen), es);
    check({tag, " first_diff_idx"}, int'(first_diff_idx), ef);
  endtask

  // Reference: plain counting over the stored samples.
  task automatic model(input int n, output int e1, output int e2,
                       output int ed, output int es, output int ef);
    e1 = 0; e2 = 0; ed = 0; es = 0; ef = 0;
    for (int i = 0; i < n; i++) begin
      e1 += int'(s_a1[i]);
      e2 += int'(s_a2[i]);
      if (s_a1[i] != s_a2[i]) begin
        ed++;
        if (es == 0) begin
          es = 1;
          ef = i;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a window; in_valid is asserted too and must be ignored in IDLE.
  task automatic start_window(input int len);
    start    = 1'b1;
    win_len  = len[7:0];
    in_valid = 1'b1;
    ans1     = 1'b1;
    ans2     = 1'b0;
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    check("busy after start", int'(busy), 1);
    check("out_valid after start", int'(out_valid), (len == 0) ? 1 : 0);
  endtask

  // Feed n stored samples with their gaps; out_ready toggles randomly
  // (no effect outside REPORT) and is dropped right after the last sample.
  task automatic feed(input int n, input bit rnd_ready);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < s_gap[i]; g++) begin
        in_valid  = 1'b0;
        ans1      = 1'($urandom);
        ans2      = 1'($urandom);
        out_ready = rnd_ready ? 1'($urandom) : 1'b0;
        tick();
      end
      in_valid  = 1'b1;
      ans1      = s_a1[i];
      ans2      = s_a2[i];
      out_ready = rnd_ready ? 1'($urandom) : 1'b0;
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      if (i < n - 1) begin
        if (out_valid !== 1'b0) begin
          check("out_valid early", int'(out_valid), 0);
        end
      end
    end
    check("out_valid after last sample", int'(out_valid), 1);
    check("busy in report", int'(busy), 1);
  endtask

  // Complete the handshake and confirm the record survives in IDLE.
  task automatic handshake(input string tag, input int e1, input int e2,
                           input int ed, input int es, input int ef);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " out_valid after ready"}, int'(out_valid), 0);
    check({tag, " busy after ready"}, int'(busy), 0);
    tick();
    check_record({tag, " idle hold"}, e1, e2, ed, es, ef);
  endtask

  initial begin
    int e1, e2, ed, es, ef;
    int len;
    logic [7:0] snap1, snap2, snapd, snapf;
    logic       snaps;

    vt[0] = '{4, 8'h0F, 8'h0F, 8'h00, 4, 4, 0, 0, 0};
    vt[1] = '{3, 8'h01, 8'h04, 8'h06, 1, 1, 2, 1, 0};
    vt[2] = '{5, 8'h0B, 8'h13, 8'h00, 3, 3, 2, 1, 3};
    vt[3] = '{1, 8'h00, 8'h01, 8'h00, 0, 1, 1, 1, 0};
    vt[4] = '{8, 8'hA5, 8'h5A, 8'h24, 4, 4, 8, 1, 0};
    vt[5] = '{6, 8'h20, 8'h00, 8'h09, 1, 0, 1, 1, 5};

    reset = 1'b1; start = 1'b0; win_len = 8'd0; in_valid = 1'b0;
    ans1 = 1'b0; ans2 = 1'b0; out_ready = 1'b0;
    #3;
    check("reset busy", int'(busy), 0);
    check("reset out_valid", int'(out_valid), 0);
    check_record("reset", 0, 0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset in the middle of a window discards it.
    for (int i = 0; i < 3; i++) begin
      s_a1[i] = 1'b1; s_a2[i] = 1'b0; s_gap[i] = 0;
    end
    start_window(5);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; ans1 = s_a1[i]; ans2 = s_a2[i];
      tick();
    end
    in_valid = 1'b0;
    check("pre-reset cnt1", int'(cnt1), 3);
    reset = 1'b1;
    #1;
    check("midreset busy", int'(busy), 0);
    check("midreset out_valid", int'(out_valid), 0);
    check_record("midreset", 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    tick();
    check("after reset out_valid", int'(out_valid), 0);
    s_a1[0] = 1'b1; s_a2[0] = 1'b0; s_gap[0] = 0;
    s_a1[1] = 1'b1; s_a2[1] = 1'b1; s_gap[1] = 1;
    start_window(2);
    feed(2, 1'b0);
    model(2, e1, e2, ed, es, ef);
    check_record("post-reset window", e1, e2, ed, es, ef);
    handshake("post-reset", e1, e2, ed, es, ef);

    // Directed vector table.
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < vt[v].len; i++) begin
        s_a1[i]  = vt[v].a1[i];
        s_a2[i]  = vt[v].a2[i];
        s_gap[i] = int'(vt[v].gap[i]);
      end
      start_window(vt[v].len);
      feed(vt[v].len, 1'b0);
      check_record($sformatf("vec%0d", v), vt[v].e1, vt[v].e2, vt[v].ed, vt[v].es, vt[v].ef);
      handshake($sformatf("vec%0d", v), vt[v].e1, vt[v].e2, vt[v].ed, vt[v].es, vt[v].ef);
    end

    // Backpressure: record held while start/in_valid are driven in REPORT.
    s_a1[0] = 1'b0; s_a2[0] = 1'b1; s_gap[0] = 0;
    s_a1[1] = 1'b1; s_a2[1] = 1'b1; s_gap[1] = 0;
    s_a1[2] = 1'b1; s_a2[2] = 1'b0; s_gap[2] = 2;
    start_window(3);
    feed(3, 1'b0);
    model(3, e1, e2, ed, es, ef);
    check_record("bp", e1, e2, ed, es, ef);
    snap1 = cnt1; snap2 = cnt2; snapd = cnt_diff; snaps = diff_seen; snapf = first_diff_idx;
    for (int c = 0; c < 5; c++) begin
      start = 1'b1; win_len = 8'd7; in_valid = 1'b1;
      ans1 = 1'($urandom); ans2 = 1'($urandom);
      tick();
      check("bp out_valid held", int'(out_valid), 1);
      check_record("bp held", int'(snap1), int'(snap2), int'(snapd), int'(snaps), int'(snapf));
    end
    // start together with the handshake must not open a new window
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0; start = 1'b0; in_valid = 1'b0;
    check("bp out_valid after ready", int'(out_valid), 0);
    check("bp busy after ready", int'(busy), 0);
    tick();
    check("bp still idle", int'(busy), 0);
    check_record("bp idle hold", e1, e2, ed, es, ef);

    // Zero-length window.
    start_window(0);
    check_record("zero", 0, 0, 0, 0, 0);
    handshake("zero", 0, 0, 0, 0, 0);

    // Maximum-length window, all (1,0).
    for (int i = 0; i < 255; i++) begin
      s_a1[i] = 1'b1; s_a2[i] = 1'b0; s_gap[i] = 0;
    end
    start_window(255);
    feed(255, 1'b0);
    check_record("max", 255, 0, 255, 1, 0);
    handshake("max", 255, 0, 255, 1, 0);

    // Randomized windows against the model.
    for (int w = 0; w < 25; w++) begin
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) begin
        s_a1[i]  = 1'($urandom);
        s_a2[i]  = ($urandom_range(0, 3) == 0) ? ~s_a1[i] : s_a1[i];
        s_gap[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      end
      start_window(len);
      feed(len, 1'b1);
      model(len, e1, e2, ed, es, ef);
      check_record($sformatf("rnd%0d", w), e1, e2, ed, es, ef);
      for (int c = 0; c < $urandom_range(0, 3); c++) begin
        start = 1'($urandom); in_valid = 1'($urandom); ans1 = 1'($urandom);
        tick();
        check("rnd out_valid held", int'(out_valid), 1);
      end
      start = 1'b0; in_valid = 1'b0;
      handshake($sformatf("rnd%0d", w), e1, e2, ed, es, ef);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_cmp_result_tally
